multicycle_ctrl_fsm: RTL
========================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Multi-cycle sequencer for the 4-bit-opcode MIPS-style CPU. Steps each instruction through
//  IDLE/FETCH/DECODE/EXEC/MEM/WB and drives the datapath strobes. Handshakes with a shared
//  instruction/data memory via mem_ready, and counts retired instructions.
//  Sits between the IR opcode field and the datapath muxes, replacing single-cycle decode.
// PARAMETERS
//  MEM_TIMEOUT  15  max wait cycles for mem_ready in FETCH/MEM before entering ERR (>=1)
//  CNT_W        16  width of retired-instruction counter
// PORTS
//  clk       in   1      rising-edge clock
//  rst_n     in   1      asynchronous active-low reset
//  Opcode    in   4      IR[15:12]; sampled in DECODE only
//  Zero      in   1      ALU zero flag; sampled in EXEC for BEQ
//  mem_ready in   1      memory access done this cycle (FETCH/MEM)
//  PcWr      out  1      PC write enable
//  PcSrc     out  2      00 PC+1, 01 branch target, 10 jump target
//  IrWr      out  1      IR load enable
//  IorD      out  1      0 address = PC, 1 address = ALU result
//  MemR/MemW out  1 each memory read / write strobe
//  RegWr     out  1      register-file write
//  RegDes    out  1      1 rd (R-type), 0 rt
//  AluSrc    out  1      0 register B, 1 sign-extended immediate
//  Mem2Reg   out  1      1 write-back from memory, 0 from ALU
//  AluOp     out  2      00 add, 01 sub, 10 funct from opcode
//  Err       out  1      sticky; set on timeout (and illegal op, see CONFIGURATION)
//  instr_cnt out  CNT_W  retired instructions, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT (R-type); 5 ADDI; 6 ST; 7 LD; 8 BEQ; 9 J; 10 NOP; 11-15 illegal.
//  Reset: state=IDLE, op_q=0, wait_cnt=0, Err=0, instr_cnt=0; every strobe output 0.
//  Outputs are combinational from state, op_q, Zero, mem_ready; unlisted strobes are 0.
//  IDLE: no strobes; -> FETCH next cycle.
//  FETCH: MemR=1, IorD=0; on mem_ready: IrWr=1, PcWr=1, PcSrc=00, -> DECODE; else stay.
//  DECODE: op_q<=Opcode. J: PcWr=1, PcSrc=10, retire, -> FETCH. NOP/illegal: retire, -> FETCH.
//    All others -> EXEC.
//  EXEC: R-type AluSrc=0, AluOp=10 -> WB. ADDI AluSrc=1, AluOp=00 -> WB. LD/ST AluSrc=1, AluOp=00 -> MEM.
//    BEQ AluSrc=0, AluOp=01, PcWr=Zero, PcSrc=01, retire, -> FETCH.
//  MEM: IorD=1, MemR=(LD) or MemW=(ST), held until mem_ready. ST: retire, -> FETCH. LD: -> WB.
//  WB: RegWr=1; RegDes=1 R-type else 0; Mem2Reg=1 LD only; retire, -> FETCH.
//  Latency (mem_ready immediate): J/NOP 2, BEQ 3, R/ADDI/ST 4, LD 5 cycles.
//  wait_cnt: clears on entry to FETCH/MEM and on mem_ready; increments each not-ready cycle.
//    Reaching MEM_TIMEOUT without mem_ready -> ERR. mem_ready on that same cycle wins; no ERR.
//  ERR: terminal; all strobes 0, Err=1, instr_cnt frozen; exits only via rst_n.
//  "retire" = instr_cnt+1 on the transition edge; 2^CNT_W-1 wraps to 0.
//  rst_n low mid-access: strobes drop asynchronously; in-flight MemW is abandoned.
// CONFIGURATION
//  MULTICYCLE_ILLEGAL_TRAP_EN defined: opcodes 11-15 in DECODE -> ERR (Err=1), not retired.
//  Undefined: opcodes 11-15 execute as NOP (retired, PC already advanced).
// STRUCTURE
//  Shared package/include multicycle_ctrl_defs.vh: opcode localparams, state encodings (3 bits),
//    PcSrc and AluOp encodings; shared with the testbench.
//  Sub-module multicycle_op_class: combinational Opcode -> {is_r, is_addi, is_ld, is_st, is_beq,
//    is_j, is_nop, is_illegal}.
//  Top: state register, op_q, wait_cnt, instr_cnt, output decode.
// TESTING
//  ADD (op 0), mem_ready tied 1 -> 4-cycle sequence; RegWr=1, RegDes=1 in WB; instr_cnt 0->1.
//  LD (op 7), mem_ready low 3 cycles in MEM -> MemR, IorD=1 held 4 cycles; WB Mem2Reg=1, RegDes=0.
//  BEQ (op 8), Zero=1 -> PcWr=1, PcSrc=01 in EXEC. Repeat with Zero=0 -> PcWr=0. Both retire.
//  mem_ready held 0 in FETCH -> Err=1 after 15 cycles; ERR held until rst_n pulse, then IDLE.
//  Opcode 12: with macro -> Err=1, instr_cnt unchanged; without macro -> retired as NOP in 2 cycles.
//  CNT_W=4: 16 NOPs -> instr_cnt wraps 15->0. Assert rst_n low during ST MEM -> MemW=0 at once.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared definitions for the multi-cycle control sequencer: opcode values,
// the 3-bit state encoding, PcSrc/AluOp encodings and the opcode class record.
package multicycle_ctrl_fsm_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_ST   = 4'd6;
    localparam logic [3:0] OP_LD   = 4'd7;
    localparam logic [3:0] OP_BEQ  = 4'd8;
    localparam logic [3:0] OP_J    = 4'd9;
    localparam logic [3:0] OP_NOP  = 4'd10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

    localparam logic [1:0] PCSRC_INC   = 2'b00;
    localparam logic [1:0] PCSRC_BR    = 2'b01;
    localparam logic [1:0] PCSRC_JMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic is_r;
        logic is_addi;
        logic is_ld;
        logic is_st;
        logic is_beq;
        logic is_j;
        logic is_nop;
        logic is_illegal;
    } op_class_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control/handshake bundle between the sequencer (master) and the
// datapath/memory side (slave). Port names follow the CPU's datapath naming.
interface multicycle_ctrl_fsm_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       Opcode;
    logic             Zero;
    logic             mem_ready;
    logic             PcWr;
    logic [1:0]       PcSrc;
    logic             IrWr;
    logic             IorD;
    logic             MemR;
    logic             MemW;
    logic             RegWr;
    logic             RegDes;
    logic             AluSrc;
    logic             Mem2Reg;
    logic [1:0]       AluOp;
    logic             Err;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  Opcode, Zero, mem_ready,
        output PcWr, PcSrc, IrWr, IorD, MemR, MemW, RegWr, RegDes,
               AluSrc, Mem2Reg, AluOp, Err, instr_cnt
    );

    modport slave (
        output Opcode, Zero, mem_ready,
        input  PcWr, PcSrc, IrWr, IorD, MemR, MemW, RegWr, RegDes,
               AluSrc, Mem2Reg, AluOp, Err, instr_cnt
    );
endinterface

// File: rtl/multicycle_op_class.sv
// Opcode classifier: maps the 4-bit opcode onto one-hot class flags.
// Opcodes 11-15 are reported as illegal.
module multicycle_op_class
    import multicycle_ctrl_fsm_pkg::*;
(
    input  logic [3:0] i_opcode,
    output op_class_t  o_class
);

    // Decode opcode into exactly one class flag
    always_comb begin
        o_class = 8'h00;
        case (i_opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: o_class.is_r = 1'b1;
            OP_ADDI: o_class.is_addi = 1'b1;
            OP_ST:   o_class.is_st   = 1'b1;
            OP_LD:   o_class.is_ld   = 1'b1;
            OP_BEQ:  o_class.is_beq  = 1'b1;
            OP_J:    o_class.is_j    = 1'b1;
            OP_NOP:  o_class.is_nop  = 1'b1;
            default: o_class.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer: IDLE/FETCH/DECODE/EXEC/MEM/WB with a
// terminal ERR state on memory timeout. Strobes are decoded combinationally
// from the state, the latched opcode, Zero and mem_ready so memory handshakes
// complete in the same cycle. Define MULTICYCLE_ILLEGAL_TRAP_EN to send
// opcodes 11-15 to ERR instead of retiring them as NOPs.
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_ctrl_fsm_if.master bus
);

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_e           r_state;
    logic [3:0]       r_op;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] r_instr_cnt;

    op_class_t w_dec_cls;
    op_class_t w_op_cls;
    logic      w_timeout;
    logic      w_trap;
    logic      w_unused_cls;

    logic       w_pcwr, w_irwr, w_iord, w_memr, w_memw, w_regwr;
    logic       w_regdes, w_alusrc, w_mem2reg, w_err;
    logic [1:0] w_pcsrc, w_aluop;

    // Live opcode drives DECODE decisions; latched opcode drives later phases
    multicycle_op_class u_dec_class (.i_opcode(bus.Opcode), .o_class(w_dec_cls));
    multicycle_op_class u_op_class  (.i_opcode(r_op),       .o_class(w_op_cls));

    // Classes that never reach EXEC/MEM/WB are irrelevant for the latched opcode
    assign w_unused_cls = ^{w_op_cls.is_j, w_op_cls.is_nop, w_op_cls.is_illegal};

    // Last permitted wait cycle without ready; ready on that cycle still wins
    assign w_timeout = ~bus.mem_ready & (r_wait_cnt == WAIT_LAST);

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    assign w_trap = w_dec_cls.is_illegal;
`else
    assign w_trap = 1'b0;
`endif

    // Sequencer state, latched opcode, memory wait counter and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= 4'd0;
            r_wait_cnt  <= {WAIT_W{1'b0}};
            r_instr_cnt <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state    <= ST_FETCH;
                    r_wait_cnt <= {WAIT_W{1'b0}};
                end
                ST_FETCH: begin
                    if (bus.mem_ready) begin
                        r_state    <= ST_DECODE;
                        r_wait_cnt <= {WAIT_W{1'b0}};
                    end else if (w_timeout) begin
                        r_state <= ST_ERR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                ST_DECODE: begin
                    r_op <= bus.Opcode;
                    if (w_trap) begin
                        r_state <= ST_ERR;
                    end else if (w_dec_cls.is_j | w_dec_cls.is_nop | w_dec_cls.is_illegal) begin
                        r_state     <= ST_FETCH;
                        r_wait_cnt  <= {WAIT_W{1'b0}};
                        r_instr_cnt <= r_instr_cnt + CNT_W'(1);
                    end else begin
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (w_op_cls.is_beq) begin
                        r_state     <= ST_FETCH;
                        r_wait_cnt  <= {WAIT_W{1'b0}};
                        r_instr_cnt <= r_instr_cnt + CNT_W'(1);
                    end else if (w_op_cls.is_ld | w_op_cls.is_st) begin
                        r_state    <= ST_MEM;
                        r_wait_cnt <= {WAIT_W{1'b0}};
                    end else begin
                        r_state <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (bus.mem_ready) begin
                        r_wait_cnt <= {WAIT_W{1'b0}};
                        if (w_op_cls.is_st) begin
                            r_state     <= ST_FETCH;
                            r_instr_cnt <= r_instr_cnt + CNT_W'(1);
                        end else begin
                            r_state <= ST_WB;
                        end
                    end else if (w_timeout) begin
                        r_state <= ST_ERR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                ST_WB: begin
                    r_state     <= ST_FETCH;
                    r_wait_cnt  <= {WAIT_W{1'b0}};
                    r_instr_cnt <= r_instr_cnt + CNT_W'(1);
                end
                ST_ERR: begin
                    r_state <= ST_ERR;
                end
                default: begin
                    r_state <= ST_ERR;
                end
            endcase
        end
    end

    // Datapath strobe decode; anything not driven in a phase stays 0
    always_comb begin
        w_pcwr    = 1'b0;
        w_pcsrc   = PCSRC_INC;
        w_irwr    = 1'b0;
        w_iord    = 1'b0;
        w_memr    = 1'b0;
        w_memw    = 1'b0;
        w_regwr   = 1'b0;
        w_regdes  = 1'b0;
        w_alusrc  = 1'b0;
        w_mem2reg = 1'b0;
        w_aluop   = ALUOP_ADD;
        w_err     = (r_state == ST_ERR);
        case (r_state)
            ST_FETCH: begin
                w_memr = 1'b1;
                if (bus.mem_ready) begin
                    w_irwr  = 1'b1;
                    w_pcwr  = 1'b1;
                    w_pcsrc = PCSRC_INC;
                end else begin
                    w_irwr = 1'b0;
                end
            end
            ST_DECODE: begin
                if (w_dec_cls.is_j & ~w_trap) begin
                    w_pcwr  = 1'b1;
                    w_pcsrc = PCSRC_JMP;
                end else begin
                    w_pcwr = 1'b0;
                end
            end
            ST_EXEC: begin
                if (w_op_cls.is_beq) begin
                    w_aluop = ALUOP_SUB;
                    w_pcwr  = bus.Zero;
                    w_pcsrc = PCSRC_BR;
                end else if (w_op_cls.is_r) begin
                    w_aluop = ALUOP_FUNCT;
                end else if (w_op_cls.is_addi | w_op_cls.is_ld | w_op_cls.is_st) begin
                    w_alusrc = 1'b1;
                    w_aluop  = ALUOP_ADD;
                end else begin
                    w_alusrc = 1'b0;
                end
            end
            ST_MEM: begin
                w_iord = 1'b1;
                w_memr = w_op_cls.is_ld;
                w_memw = w_op_cls.is_st;
            end
            ST_WB: begin
                w_regwr   = 1'b1;
                w_regdes  = w_op_cls.is_r;
                w_mem2reg = w_op_cls.is_ld;
            end
            default: begin
                w_pcwr = 1'b0;
            end
        endcase
    end

    assign bus.PcWr      = w_pcwr;
    assign bus.PcSrc     = w_pcsrc;
    assign bus.IrWr      = w_irwr;
    assign bus.IorD      = w_iord;
    assign bus.MemR      = w_memr;
    assign bus.MemW      = w_memw;
    assign bus.RegWr     = w_regwr;
    assign bus.RegDes    = w_regdes;
    assign bus.AluSrc    = w_alusrc;
    assign bus.Mem2Reg   = w_mem2reg;
    assign bus.AluOp     = w_aluop;
    assign bus.Err       = w_err;
    assign bus.instr_cnt = r_instr_cnt;

endmodule
